mmio_timer: RTL and testbench
=============================

# mmio_timer

Memory-mapped machine timer that responds on the core's data bus: `bus_address`, `bus_read_data`, `bus_write_data`, `bus_byte_enable`, `bus_read_enable`, `bus_write_enable`. It holds a free-running 64-bit `mtime`, a 64-bit `mtimecmp` and a control register, and raises a level timer interrupt when `mtime >= mtimecmp`. It sits beside data memory on the core bus and returns read data in the same cycle, as the single-cycle core requires.

## Interface
- `BASE_ADDRESS`, default `32'hFFFF_8000`: byte address of the register window; must be 64-byte aligned.
- `clock  input  1`: single clock; all state updates on the rising edge.
- `reset  input  1`: asynchronous, active-high.
- `bus_address  input  32`: byte address from the initiator.
- `bus_write_data  input  32`: write data, already lane-positioned by the initiator.
- `bus_byte_enable  input  4`: per-byte write lane enables.
- `bus_read_enable  input  1`: read strobe.
- `bus_write_enable  input  1`: write strobe.
- `bus_read_data  output  32`: register read data; combinational.
- `timer_interrupt  output  1`: registered level interrupt.

## Operation
- Select condition: `bus_address[31:6] == BASE_ADDRESS[31:6]`. `bus_address[1:0]` is ignored.
- Register map (offsets from `BASE_ADDRESS`):
  - 0x00: `mtime[31:0]`
  - 0x04: `mtime[63:32]`
  - 0x08: `mtimecmp[31:0]`
  - 0x0C: `mtimecmp[63:32]`
  - 0x10: `ctrl`. Bit 0 is `enable` (R/W). Bit 1 is `pending` (read-only, equals `timer_interrupt`).
  - 0x14: `prescale[15:0]` (see Configuration).
  - Other offsets read 0; writes to them are ignored.
- Reads: `bus_read_data` shows the addressed register when selected and `bus_read_enable` is high. Otherwise it is 0.
- Writes: on the clock edge when selected and `bus_write_enable` is high. Only the bytes enabled by `bus_byte_enable` are updated.
- Counting: while `enable` = 1 and a tick occurs, `mtime <= mtime + 1`. The add is 64-bit and wraps from all-ones to 0. Carry from the low word into the high word is inherent.
- Write/increment collision: a write to 0x00 or 0x04 suppresses that cycle's increment. The new `mtime` is the byte-merged write over the pre-increment value; the unwritten half is kept.
- Compare: unsigned 64-bit, `hit = mtime >= mtimecmp`. `timer_interrupt <= hit & enable` every cycle.
- Clearing the interrupt: write a larger `mtimecmp`, or clear `enable`.

## Timing
- Reset values:
  - `mtime` = 0
  - `mtimecmp` = `64'hFFFF_FFFF_FFFF_FFFF`
  - `enable` = 0
  - `prescale` = 0
  - `timer_interrupt` = 0
  - `bus_read_data` = 0 while no read is selected.
- Read latency: zero cycles. Reading `mtime` in cycle N returns the value registered at the start of cycle N, before that cycle's increment.
- Register writes: visible on `bus_read_data` from cycle N+1.
- Interrupt latency: the condition becomes true in registered state at edge N, and `timer_interrupt` rises at edge N+1. It deasserts with the same one-cycle lag.
- Reset mid-operation: asynchronous. All state returns to reset values immediately, and any in-flight write is dropped.
- Simultaneous read and write to the same offset: the read returns the old value.

## Configuration
- Macro: `MMIO_TIMER_PRESCALE_EN`.
- Defined:
  - A 16-bit prescale counter generates ticks. A tick fires when `count == prescale`; the counter then returns to 0. Otherwise it increments.
  - `prescale` = 0 gives a tick every cycle, and N gives one tick every N+1 cycles.
  - Any write to 0x14 clears the counter. Clearing `enable` holds the counter at 0.
- Undefined:
  - Every enabled cycle is a tick.
  - Offset 0x14 reads 0; writes to it are ignored.
  - No prescale logic is synthesized.

## Structure
- Package `mmio_timer_pkg` holds:
  - register offset constants (`TIMER_MTIME_LO`, …, `TIMER_PRESCALE`);
  - `ctrl` bit positions;
  - the reset value of `mtimecmp`.
- One sub-module, `timer_prescaler`: counter plus tick generation. It is instantiated only under `MMIO_TIMER_PRESCALE_EN`.
- A byte-merge function lives in the package and is shared by all writable registers.

## Test plan
- Reset, then write `ctrl` = 1 and run 10 cycles → `mtime[31:0]` reads 10, `timer_interrupt` stays 0.
- Write `mtime` = `0x0000_0000_FFFF_FFFE` with `enable` = 1, then wait 2 cycles → reads 0x04 = 1 and 0x00 = 0 (carry).
- Set `mtimecmp` = 5, enable at `mtime` = 0 → `timer_interrupt` rises exactly when `mtime` reads 6. Writing `mtimecmp` = 100 drops it one cycle later, and `ctrl` bit 1 tracks it.
- Write `bus_byte_enable` = `4'b0010`, data `0x0000_AB00` to 0x08 → `mtimecmp[31:0]` = `0xFFFF_ABFF`, with no increment suppression on `mtime`.
- Write `mtime` low while counting → written value read next cycle with no +1; unmapped offset 0x20 reads 0.
- With `MMIO_TIMER_PRESCALE_EN`: `prescale` = 3, run 12 cycles → `mtime` advances by 3. Without the macro: 0x14 reads 0 after a write of 3.

Source files
------------

// File: rtl/mmio_timer_pkg.sv
// mmio_timer_pkg
// Shared definitions for the memory-mapped machine timer: register window
// offsets, ctrl bit positions, the mtimecmp reset value and the byte-lane
// merge helper used by every writable register.
package mmio_timer_pkg;

  // Byte offsets of the registers inside the 64-byte window
  localparam logic [5:0] TIMER_MTIME_LO    = 6'h00;
  localparam logic [5:0] TIMER_MTIME_HI    = 6'h04;
  localparam logic [5:0] TIMER_MTIMECMP_LO = 6'h08;
  localparam logic [5:0] TIMER_MTIMECMP_HI = 6'h0C;
  localparam logic [5:0] TIMER_CTRL        = 6'h10;
  localparam logic [5:0] TIMER_PRESCALE    = 6'h14;

  // ctrl register bit positions
  localparam int CTRL_ENABLE_BIT  = 0;
  localparam int CTRL_PENDING_BIT = 1;

  // mtimecmp comes out of reset at all-ones so no interrupt fires by accident
  localparam logic [63:0] MTIMECMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF;

  // Replace only the byte lanes selected by byteEnable
  function automatic logic [31:0] byteMerge(input logic [31:0] oldValue,
                                            input logic [31:0] newValue,
                                            input logic [3:0]  byteEnable);
    logic [31:0] merged;
    merged = oldValue;
    for (int i = 0; i < 4; i++) begin
      if (byteEnable[i]) begin
        merged[8*i +: 8] = newValue[8*i +: 8];
      end
    end
    return merged;
  endfunction

endpackage

// File: rtl/timer_prescaler.sv
// timer_prescaler
// Divides the clock into mtime ticks. A tick fires when the counter equals
// the prescale value; the counter then restarts from 0.
// Ports:
//   clock, reset   - clock and asynchronous active-high reset
//   enable_i       - timer enable; while low the counter is held at 0
//   clear_i        - restarts the counter (prescale register written)
//   prescale_i     - divide value; N gives one tick every N+1 cycles
//   tick_o         - single-cycle tick for the mtime increment
module timer_prescaler
  import mmio_timer_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        enable_i,
  input  logic        clear_i,
  input  logic [15:0] prescale_i,
  output logic        tick_o
);

  logic [15:0] count_q;
  logic [15:0] count_d;

  assign tick_o = enable_i && (count_q == prescale_i);

  // A write to prescale, a disabled timer or a tick all restart the count
  always_comb begin
    count_d = count_q + 16'd1;
    if (clear_i || !enable_i || tick_o) begin
      count_d = '0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/mmio_timer.sv
// mmio_timer
// Memory-mapped machine timer on the core data bus. Holds a free-running
// 64-bit mtime, a 64-bit mtimecmp and a ctrl register, and raises a
// registered level interrupt while mtime >= mtimecmp and the timer is enabled.
// Read data is combinational so the single-cycle core sees it immediately.
// Optional feature: define MMIO_TIMER_PRESCALE_EN to add the 16-bit
// prescale register at offset 0x14 and the timer_prescaler tick divider.
// Ports:
//   clock, reset      - clock and asynchronous active-high reset
//   bus_address       - byte address; window selected on bits [31:6]
//   bus_write_data    - lane-positioned write data
//   bus_byte_enable   - per-byte write lane enables
//   bus_read_enable   - read strobe
//   bus_write_enable  - write strobe
//   bus_read_data     - register read data, 0 when not reading this window
//   timer_interrupt   - registered level timer interrupt
module mmio_timer
  import mmio_timer_pkg::*;
#(
  parameter logic [31:0] BASE_ADDRESS = 32'hFFFF_8000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] bus_address,
  input  logic [31:0] bus_write_data,
  input  logic [3:0]  bus_byte_enable,
  input  logic        bus_read_enable,
  input  logic        bus_write_enable,
  output logic [31:0] bus_read_data,
  output logic        timer_interrupt
);

  logic [63:0] mtime_q, mtime_d;
  logic [63:0] mtimeCmp_q, mtimeCmp_d;
  logic        enable_q, enable_d;
  logic        irq_q;
  logic        selected;
  logic [5:0]  regOffset;
  logic        writeActive;
  logic        wrMtimeLo, wrMtimeHi, wrCmpLo, wrCmpHi, wrCtrl;
  logic [31:0] ctrlWrite;
  logic        tick;
  logic        hit;
  logic        unusedBits;

  assign selected    = (bus_address[31:6] == BASE_ADDRESS[31:6]);
  assign regOffset   = {bus_address[5:2], 2'b00};
  assign writeActive = selected && bus_write_enable;
  assign wrMtimeLo   = writeActive && (regOffset == TIMER_MTIME_LO);
  assign wrMtimeHi   = writeActive && (regOffset == TIMER_MTIME_HI);
  assign wrCmpLo     = writeActive && (regOffset == TIMER_MTIMECMP_LO);
  assign wrCmpHi     = writeActive && (regOffset == TIMER_MTIMECMP_HI);
  assign wrCtrl      = writeActive && (regOffset == TIMER_CTRL);
  assign ctrlWrite   = byteMerge({31'b0, enable_q}, bus_write_data, bus_byte_enable);
  assign hit         = (mtime_q >= mtimeCmp_q);

`ifdef MMIO_TIMER_PRESCALE_EN
  logic [15:0] prescale_q, prescale_d;
  logic [31:0] prescaleWrite;
  logic        wrPrescale;

  assign wrPrescale    = writeActive && (regOffset == TIMER_PRESCALE);
  assign prescaleWrite = byteMerge({16'b0, prescale_q}, bus_write_data, bus_byte_enable);
  assign prescale_d    = wrPrescale ? prescaleWrite[15:0] : prescale_q;
  assign unusedBits    = ^{bus_address[1:0], ctrlWrite[31:1], prescaleWrite[31:16]};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      prescale_q <= '0;
    end else begin
      prescale_q <= prescale_d;
    end
  end

  timer_prescaler u_prescaler (
    .clock      (clock),
    .reset      (reset),
    .enable_i   (enable_q),
    .clear_i    (wrPrescale),
    .prescale_i (prescale_q),
    .tick_o     (tick)
  );
`else
  assign tick       = 1'b1;
  assign unusedBits = ^{bus_address[1:0], ctrlWrite[31:1]};
`endif

  // A bus write to either mtime half wins over the increment for that cycle;
  // the unwritten half keeps its pre-increment value
  always_comb begin
    mtime_d    = mtime_q;
    mtimeCmp_d = mtimeCmp_q;
    enable_d   = enable_q;
    if (wrMtimeLo) begin
      mtime_d[31:0] = byteMerge(mtime_q[31:0], bus_write_data, bus_byte_enable);
    end
    if (wrMtimeHi) begin
      mtime_d[63:32] = byteMerge(mtime_q[63:32], bus_write_data, bus_byte_enable);
    end
    if (!wrMtimeLo && !wrMtimeHi && enable_q && tick) begin
      mtime_d = mtime_q + 64'd1;
    end
    if (wrCmpLo) begin
      mtimeCmp_d[31:0] = byteMerge(mtimeCmp_q[31:0], bus_write_data, bus_byte_enable);
    end
    if (wrCmpHi) begin
      mtimeCmp_d[63:32] = byteMerge(mtimeCmp_q[63:32], bus_write_data, bus_byte_enable);
    end
    if (wrCtrl) begin
      enable_d = ctrlWrite[CTRL_ENABLE_BIT];
    end
  end

  // The interrupt is computed from registered state, so it lags the
  // compare condition by one cycle in both directions
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mtime_q    <= '0;
      mtimeCmp_q <= MTIMECMP_RESET;
      enable_q   <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      mtime_q    <= mtime_d;
      mtimeCmp_q <= mtimeCmp_d;
      enable_q   <= enable_d;
      irq_q      <= hit && enable_q;
    end
  end

  // Combinational read mux; reads see state from before this cycle's edge
  always_comb begin
    bus_read_data = '0;
    if (selected && bus_read_enable) begin
      case (regOffset)
        TIMER_MTIME_LO:    bus_read_data = mtime_q[31:0];
        TIMER_MTIME_HI:    bus_read_data = mtime_q[63:32];
        TIMER_MTIMECMP_LO: bus_read_data = mtimeCmp_q[31:0];
        TIMER_MTIMECMP_HI: bus_read_data = mtimeCmp_q[63:32];
        TIMER_CTRL: begin
          bus_read_data[CTRL_ENABLE_BIT]  = enable_q;
          bus_read_data[CTRL_PENDING_BIT] = irq_q;
        end
`ifdef MMIO_TIMER_PRESCALE_EN
        TIMER_PRESCALE:    bus_read_data = {16'b0, prescale_q};
`endif
        default:           bus_read_data = '0;
      endcase
    end
  end

  assign timer_interrupt = irq_q;

endmodule

// File: tb/tb_mmio_timer.sv
// tb_mmio_timer
// Self-checking bench for mmio_timer: a directed vector table, hand-written
// multi-cycle sequences and a randomized phase checked against a
// register-level reference model of the timer.
module tb_mmio_timer;

  localparam logic [31:0] BASE = 32'hFFFF_8000;
`ifdef MMIO_TIMER_PRESCALE_EN
  localparam logic [31:0] PRESCALE_READBACK = 32'd3;
`else
  localparam logic [31:0] PRESCALE_READBACK = 32'd0;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] bus_address;
  logic [31:0] bus_write_data;
  logic [3:0]  bus_byte_enable;
  logic        bus_read_enable;
  logic        bus_write_enable;
  logic [31:0] bus_read_data;
  logic        timer_interrupt;

  int checks = 0;
  int failures = 0;

  // Reference model state
  logic [63:0] mMtime;
  logic [63:0] mCmp;
  logic        mEnable;
  logic        mIrq;
  logic [15:0] mPrescale;
  logic [15:0] mCount;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
    logic        re;
    logic        we;
    logic [31:0] expRead;
  } vec_t;

  vec_t vecs[22];

  always #5 clock = ~clock;

  mmio_timer #(.BASE_ADDRESS(BASE)) dut (
    .clock            (clock),
    .reset            (reset),
    .bus_address      (bus_address),
    .bus_write_data   (bus_write_data),
    .bus_byte_enable  (bus_byte_enable),
    .bus_read_enable  (bus_read_enable),
    .bus_write_enable (bus_write_enable),
    .bus_read_data    (bus_read_data),
    .timer_interrupt  (timer_interrupt)
  );

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
    end
  endtask

  function automatic logic [31:0] mergeBytes(input logic [31:0] oldV,
                                             input logic [31:0] newV,
                                             input logic [3:0] be);
    logic [31:0] r;
    r = oldV;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = newV[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] modelRead(input logic [31:0] addr);
    if (addr[31:6] != BASE[31:6]) return 32'd0;
    case (addr[5:2])
      4'd0: return mMtime[31:0];
      4'd1: return mMtime[63:32];
      4'd2: return mCmp[31:0];
      4'd3: return mCmp[63:32];
      4'd4: return {30'd0, mIrq, mEnable};
`ifdef MMIO_TIMER_PRESCALE_EN
      4'd5: return {16'd0, mPrescale};
`endif
      default: return 32'd0;
    endcase
  endfunction

  task automatic modelReset();
    mMtime    = 64'd0;
    mCmp      = 64'hFFFF_FFFF_FFFF_FFFF;
    mEnable   = 1'b0;
    mIrq      = 1'b0;
    mPrescale = 16'd0;
    mCount    = 16'd0;
  endtask

  // Advance the model by one clock edge, all from pre-edge values
  task automatic modelStep(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] be, input logic we);
    logic        w;
    logic [3:0]  idx;
    logic        tick;
    logic [63:0] nMtime;
    logic [63:0] nCmp;
    logic        nEnable;
    logic [15:0] nPrescale;
    logic [15:0] nCount;
    logic [31:0] tmp;
    w = we && (addr[31:6] == BASE[31:6]);
    idx = addr[5:2];
    nMtime = mMtime;
    nCmp = mCmp;
    nEnable = mEnable;
    nPrescale = mPrescale;
    nCount = 16'd0;
`ifdef MMIO_TIMER_PRESCALE_EN
    tick = mEnable && (mCount == mPrescale);
    if (!(w && idx == 4'd5) && mEnable && !tick) nCount = mCount + 16'd1;
`else
    tick = mEnable;
`endif
    if (w && idx == 4'd0) nMtime[31:0] = mergeBytes(mMtime[31:0], data, be);
    if (w && idx == 4'd1) nMtime[63:32] = mergeBytes(mMtime[63:32], data, be);
    if (!(w && (idx == 4'd0 || idx == 4'd1)) && tick) nMtime = mMtime + 64'd1;
    if (w && idx == 4'd2) nCmp[31:0] = mergeBytes(mCmp[31:0], data, be);
    if (w && idx == 4'd3) nCmp[63:32] = mergeBytes(mCmp[63:32], data, be);
    if (w && idx == 4'd4 && be[0]) nEnable = data[0];
    if (w && idx == 4'd5) begin
      tmp = mergeBytes({16'd0, mPrescale}, data, be);
      nPrescale = tmp[15:0];
    end
    mIrq      = (mMtime >= mCmp) && mEnable;
    mMtime    = nMtime;
    mCmp      = nCmp;
    mEnable   = nEnable;
    mPrescale = nPrescale;
    mCount    = nCount;
  endtask

  // One bus cycle: drive, sample read data and interrupt, step the model, clock
  task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] data,
                               input logic [3:0] be, input logic re, input logic we,
                               output logic [31:0] rdata, output logic irqSeen);
    bus_address      = addr;
    bus_write_data   = data;
    bus_byte_enable  = be;
    bus_read_enable  = re;
    bus_write_enable = we;
    #1;
    rdata   = bus_read_data;
    irqSeen = timer_interrupt;
    checkOutput("irq vs model", {63'd0, timer_interrupt}, {63'd0, mIrq});
    modelStep(addr, data, be, we);
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic writeReg(input logic [31:0] off, input logic [31:0] data);
    logic [31:0] rd;
    logic irqS;
    applyStimulus(BASE + off, data, 4'hF, 1'b0, 1'b1, rd, irqS);
  endtask

  task automatic readReg(input logic [31:0] off, output logic [31:0] rd);
    logic irqS;
    applyStimulus(BASE + off, 32'd0, 4'h0, 1'b1, 1'b0, rd, irqS);
  endtask

  task automatic idle(input int n);
    logic [31:0] rd;
    logic irqS;
    for (int i = 0; i < n; i++) applyStimulus(32'd0, 32'd0, 4'h0, 1'b0, 1'b0, rd, irqS);
  endtask

  // Assert reset mid-cycle with a ctrl write in flight; the write must be lost
  task automatic doReset();
    logic [31:0] rd;
    bus_address      = BASE + 32'h10;
    bus_write_data   = 32'd1;
    bus_byte_enable  = 4'hF;
    bus_read_enable  = 1'b1;
    bus_write_enable = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    checkOutput("reset async irq", {63'd0, timer_interrupt}, 64'd0);
    checkOutput("reset async ctrl read", {32'd0, bus_read_data}, 64'd0);
    modelReset();
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    bus_read_enable  = 1'b0;
    bus_write_enable = 1'b0;
    readReg(32'h10, rd);
    checkOutput("reset ctrl dropped write", {32'd0, rd}, 64'd0);
    readReg(32'h00, rd);
    checkOutput("reset mtime lo", {32'd0, rd}, 64'd0);
    readReg(32'h0C, rd);
    checkOutput("reset mtimecmp hi", {32'd0, rd}, 64'hFFFF_FFFF);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog timeout actual=running required=finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic [31:0] v0;
    logic [31:0] expRd;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
    logic        re;
    logic        we;
    logic        irqS;
    logic        found;

    vecs[0]  = '{BASE + 32'h08, 32'h0000_0000, 4'h0, 1'b1, 1'b0, 32'hFFFF_FFFF};
    vecs[1]  = '{BASE + 32'h08, 32'h0000_AB00, 4'h2, 1'b0, 1'b1, 32'h0000_0000};
    vecs[2]  = '{BASE + 32'h08, 32'h0000_0000, 4'h0, 1'b1, 1'b0, 32'hFFFF_ABFF};
    vecs[3]  = '{BASE + 32'h0C, 32'h0000_0000, 4'h0, 1'b1, 1'b0, 32'hFFFF_FFFF};
    vecs[4]  = '{BASE + 32'h00, 32'h1234_5678, 4'hF, 1'b0, 1'b1, 32'h0000_0000};
    vecs[5]  = '{BASE + 32'h00, 32'h0000_0000, 4'h0, 1'b1, 1'b0, 32'h1234_5678};
    vecs[6]  = '{BASE + 32'h02, 32'h0000_0000, 4'h0, 1'b1, 1'b0, 32'h1234_5678};
    vecs[7]  = '{BASE + 32'h20, 32'hFFFF_FFFF, 4'hF, 1'b0, 1'b1, 32'h0000_0000};
    vecs[8]  = '{BASE + 32'h20, 32'h0000_0000, 4'h0, 1'b1, 1'b0, 32'h0000_0000};
    vecs[9]  = '{32'h0000_1000, 32'h0000_0000, 4'h0, 1'b1, 1'b0, 32'h0000_0000};
    vecs[10] = '{BASE + 32'h00, 32'h0000_0000, 4'h0, 1'b0, 1'b0, 32'h0000_0000};
    vecs[11] = '{BASE + 32'h04, 32'hAA00_0000, 4'h8, 1'b0, 1'b1, 32'h0000_0000};
    vecs[12] = '{BASE + 32'h04, 32'h0000_0000, 4'h0, 1'b1, 1'b0, 32'hAA00_0000};
    vecs[13] = '{BASE + 32'h00, 32'h0000_0000, 4'hF, 1'b1, 1'b1, 32'h1234_5678};
    vecs[14] = '{BASE + 32'h00, 32'h0000_0000, 4'h0, 1'b1, 1'b0, 32'h0000_0000};
    vecs[15] = '{BASE + 32'h10, 32'h0000_0000, 4'h0, 1'b1, 1'b0, 32'h0000_0000};
    vecs[16] = '{BASE + 32'h14, 32'h0000_0003, 4'hF, 1'b0, 1'b1, 32'h0000_0000};
    vecs[17] = '{BASE + 32'h14, 32'h0000_0000, 4'h0, 1'b1, 1'b0, PRESCALE_READBACK};
    vecs[18] = '{BASE + 32'h14, 32'h0000_0000, 4'hF, 1'b0, 1'b1, 32'h0000_0000};
    vecs[19] = '{BASE + 32'h3C, 32'h0000_0000, 4'h0, 1'b1, 1'b0, 32'h0000_0000};
    vecs[20] = '{BASE + 32'h40, 32'hFFFF_FFFF, 4'hF, 1'b0, 1'b1, 32'h0000_0000};
    vecs[21] = '{BASE + 32'h00, 32'h0000_0000, 4'h0, 1'b1, 1'b0, 32'h0000_0000};

    reset            = 1'b1;
    bus_address      = 32'd0;
    bus_write_data   = 32'd0;
    bus_byte_enable  = 4'h0;
    bus_read_enable  = 1'b0;
    bus_write_enable = 1'b0;
    modelReset();
    #3;
    checkOutput("reset idle read data", {32'd0, bus_read_data}, 64'd0);
    checkOutput("reset irq", {63'd0, timer_interrupt}, 64'd0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;

    readReg(32'h00, rd);
    checkOutput("reset mtime lo read", {32'd0, rd}, 64'd0);
    readReg(32'h04, rd);
    checkOutput("reset mtime hi read", {32'd0, rd}, 64'd0);
    readReg(32'h14, rd);
    checkOutput("reset prescale read", {32'd0, rd}, 64'd0);

    for (int i = 0; i < 22; i++) begin
      applyStimulus(vecs[i].addr, vecs[i].data, vecs[i].be, vecs[i].re, vecs[i].we, rd, irqS);
      checkOutput($sformatf("vector %0d read", i), {32'd0, rd}, {32'd0, vecs[i].expRead});
    end

    // Enable and count ten cycles from zero
    doReset();
    writeReg(32'h10, 32'd1);
    idle(10);
    readReg(32'h00, rd);
    checkOutput("count 10 mtime lo", {32'd0, rd}, 64'd10);
    checkOutput("count 10 irq low", {63'd0, timer_interrupt}, 64'd0);

    // Carry from the low word into the high word
    writeReg(32'h00, 32'hFFFF_FFFE);
    idle(2);
    readReg(32'h00, rd);
    checkOutput("carry mtime lo", {32'd0, rd}, 64'd0);
    readReg(32'h04, rd);
    checkOutput("carry mtime hi", {32'd0, rd}, 64'd1);

    // Interrupt rises when mtime reads 6 with mtimecmp = 5
    doReset();
    writeReg(32'h08, 32'd5);
    writeReg(32'h0C, 32'd0);
    writeReg(32'h10, 32'd1);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      applyStimulus(BASE, 32'd0, 4'h0, 1'b1, 1'b0, rd, irqS);
      if (irqS) begin
        found = 1'b1;
        checkOutput("irq rise mtime value", {32'd0, rd}, 64'd6);
      end
    end
    if (!found) checkOutput("irq rise timeout", 64'd0, 64'd1);
    readReg(32'h10, rd);
    checkOutput("ctrl pending set", {32'd0, rd}, 64'd3);
    writeReg(32'h08, 32'd100);
    readReg(32'h10, rd);
    checkOutput("ctrl pending lag", {32'd0, rd}, 64'd3);
    readReg(32'h10, rd);
    checkOutput("ctrl pending cleared", {32'd0, rd}, 64'd1);
    checkOutput("irq cleared", {63'd0, timer_interrupt}, 64'd0);

    // A byte write to mtimecmp must not stall mtime
    readReg(32'h00, v0);
    applyStimulus(BASE + 32'h08, 32'h0000_AB00, 4'h2, 1'b0, 1'b1, rd, irqS);
    readReg(32'h00, rd);
    checkOutput("cmp write no stall", {32'd0, rd}, {32'd0, v0 + 32'd2});
    readReg(32'h08, rd);
    checkOutput("cmp byte merge", {32'd0, rd}, 64'h0000_AB64);

    // Writing mtime while counting suppresses that cycle's increment
    writeReg(32'h00, 32'h0000_0100);
    readReg(32'h00, rd);
    checkOutput("mtime write no increment", {32'd0, rd}, 64'h100);

`ifdef MMIO_TIMER_PRESCALE_EN
    writeReg(32'h14, 32'd3);
    readReg(32'h00, v0);
    idle(11);
    readReg(32'h00, rd);
    checkOutput("prescale 3 over 12 cycles", {32'd0, rd}, {32'd0, v0 + 32'd3});
    writeReg(32'h14, 32'd0);
`else
    writeReg(32'h14, 32'd3);
    readReg(32'h14, rd);
    checkOutput("prescale absent reads 0", {32'd0, rd}, 64'd0);
`endif

    // Randomized traffic against the reference model
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0) addr = (BASE ^ 32'h0000_0040) + 32'($urandom_range(0, 7) * 4);
      else addr = BASE + 32'($urandom_range(0, 7) * 4) + 32'($urandom_range(0, 3));
      data = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 64));
      be   = 4'($urandom_range(0, 15));
      re   = 1'($urandom_range(0, 1));
      we   = ($urandom_range(0, 2) == 0);
      expRd = re ? modelRead(addr) : 32'd0;
      applyStimulus(addr, data, be, re, we, rd, irqS);
      checkOutput("random read", {32'd0, rd}, {32'd0, expRd});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
